// File: rtl/rrf_commit_scheduler_pkg.sv
// Shared rename-register-file sizing constants, common to the RRF allocator
// and the commit scheduler.
package rrf_commit_scheduler_pkg;

    localparam int RRF_NUM_DEFAULT = 64;
    localparam int RRF_SEL_DEFAULT = 6;

endpackage

// File: rtl/rrf_commit_scheduler.sv
// In-order commit scheduler for the rename register file: tracks per-entry
// valid/done state and retires up to two completed entries per cycle.
module rrf_commit_scheduler
    import rrf_commit_scheduler_pkg::*;
#(
    parameter int RRF_NUM = RRF_NUM_DEFAULT,
    parameter int RRF_SEL = RRF_SEL_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         dp_alloc_num_i,
    input  logic [RRF_SEL-1:0] dp_rrftag_i,
    input  logic               wb1_en_i,
    input  logic               wb2_en_i,
    input  logic [RRF_SEL-1:0] wb1_rrftag_i,
    input  logic [RRF_SEL-1:0] wb2_rrftag_i,
    input  logic               stall_com_i,
    output logic [1:0]         com_inst_num_o,
    output logic               com_en1_o,
    output logic               com_en2_o,
    output logic [RRF_SEL-1:0] comptr_o,
    output logic [RRF_SEL-1:0] comptr2_o,
    output logic [RRF_SEL:0]   busy_num_o
);

    localparam logic [RRF_SEL-1:0] LAST_TAG = RRF_SEL'(RRF_NUM - 1);
    localparam logic [RRF_SEL-1:0] ONE_TAG  = RRF_SEL'(1);

    function automatic logic [RRF_SEL-1:0] wrap_inc(input logic [RRF_SEL-1:0] tag);
        return (tag == LAST_TAG) ? '0 : tag + ONE_TAG;
    endfunction

    logic [RRF_NUM-1:0] valid;
    logic [RRF_NUM-1:0] done;
    logic [RRF_NUM-1:0] valid_nxt;
    logic [RRF_NUM-1:0] done_nxt;
    logic [RRF_SEL-1:0] comptr;
    logic [RRF_SEL-1:0] comptr2;
    logic [RRF_SEL-1:0] comptr_nxt;
    logic [RRF_SEL-1:0] alloc_tag2;
    logic [RRF_SEL:0]   busy;
    logic [RRF_SEL:0]   busy_nxt;
    logic               com_en1;
    logic               com_en2;
    logic [1:0]         com_num;

    assign comptr2    = wrap_inc(comptr);
    assign alloc_tag2 = wrap_inc(dp_rrftag_i);

    // Reset gates commit so nothing retires in the cycle that abandons state.
    assign com_en1 = ~reset & ~stall_com_i & valid[comptr] & done[comptr];
    assign com_en2 = com_en1 & valid[comptr2] & done[comptr2];
    assign com_num = {1'b0, com_en1} + {1'b0, com_en2};

    // Allocation is applied last so it wins over a same-tag writeback.
    always_comb begin
        valid_nxt = valid;
        done_nxt  = done;
        if (wb1_en_i && valid[wb1_rrftag_i]) done_nxt[wb1_rrftag_i] = 1'b1;
        if (wb2_en_i && valid[wb2_rrftag_i]) done_nxt[wb2_rrftag_i] = 1'b1;
        if (com_en1) begin
            valid_nxt[comptr] = 1'b0;
            done_nxt[comptr]  = 1'b0;
        end
        if (com_en2) begin
            valid_nxt[comptr2] = 1'b0;
            done_nxt[comptr2]  = 1'b0;
        end
        if (dp_alloc_num_i != 2'd0) begin
            valid_nxt[dp_rrftag_i] = 1'b1;
            done_nxt[dp_rrftag_i]  = 1'b0;
        end
        if (dp_alloc_num_i[1]) begin
            valid_nxt[alloc_tag2] = 1'b1;
            done_nxt[alloc_tag2]  = 1'b0;
        end
    end

    assign comptr_nxt = com_en2 ? wrap_inc(comptr2) : (com_en1 ? comptr2 : comptr);
    assign busy_nxt   = busy + {{(RRF_SEL-1){1'b0}}, dp_alloc_num_i}
                             - {{(RRF_SEL-1){1'b0}}, com_num};

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= '0;
            done   <= '0;
            comptr <= '0;
            busy   <= '0;
        end else begin
            valid  <= valid_nxt;
            done   <= done_nxt;
            comptr <= comptr_nxt;
            busy   <= busy_nxt;
        end
    end

    assign com_en1_o      = com_en1;
    assign com_en2_o      = com_en2;
    assign com_inst_num_o = com_num;
    assign comptr_o       = reset ? '0 : comptr;
    assign comptr2_o      = reset ? ONE_TAG : comptr2;
    assign busy_num_o     = reset ? '0 : busy;

    // Allocator protocol errors: flagged in simulation, never recovered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (dp_alloc_num_i != 2'd3);
            assert (dp_alloc_num_i == 2'd0 || !valid[dp_rrftag_i]
                    || (com_en1 && dp_rrftag_i == comptr)
                    || (com_en2 && dp_rrftag_i == comptr2));
            assert (!dp_alloc_num_i[1] || !valid[alloc_tag2]
                    || (com_en1 && alloc_tag2 == comptr)
                    || (com_en2 && alloc_tag2 == comptr2));
            assert (int'(busy) + int'(dp_alloc_num_i) - int'(com_num) <= RRF_NUM);
        end
    end

endmodule

// File: tb/tb_rrf_commit_scheduler.sv
// Self-checking bench: in-order queue reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rrf_commit_scheduler;

    localparam int N   = 64;
    localparam int SEL = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     dp_alloc_num_i;
    logic [SEL-1:0] dp_rrftag_i;
    logic           wb1_en_i;
    logic           wb2_en_i;
    logic [SEL-1:0] wb1_rrftag_i;
    logic [SEL-1:0] wb2_rrftag_i;
    logic           stall_com_i;
    logic [1:0]     com_inst_num_o;
    logic           com_en1_o;
    logic           com_en2_o;
    logic [SEL-1:0] comptr_o;
    logic [SEL-1:0] comptr2_o;
    logic [SEL:0]   busy_num_o;

    rrf_commit_scheduler #(.RRF_NUM(N), .RRF_SEL(SEL)) dut (
        .clk            (clk),
        .reset          (reset),
        .dp_alloc_num_i (dp_alloc_num_i),
        .dp_rrftag_i    (dp_rrftag_i),
        .wb1_en_i       (wb1_en_i),
        .wb2_en_i       (wb2_en_i),
        .wb1_rrftag_i   (wb1_rrftag_i),
        .wb2_rrftag_i   (wb2_rrftag_i),
        .stall_com_i    (stall_com_i),
        .com_inst_num_o (com_inst_num_o),
        .com_en1_o      (com_en1_o),
        .com_en2_o      (com_en2_o),
        .comptr_o       (comptr_o),
        .comptr2_o      (comptr2_o),
        .busy_num_o     (busy_num_o)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight entries in program order, oldest first.
    typedef struct {
        int tag;
        bit done;
    } entry_t;

    entry_t q[$];
    int     m_head = 0;
    int     compared = 0;
    int     mismatched = 0;

    function automatic int tail();
        return (m_head + q.size()) % N;
    endfunction

    task automatic checkEq(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int an, input int tag, input bit w1, input int t1,
                                 input bit w2, input int t2, input bit st, input bit rs);
        dp_alloc_num_i = 2'(an);
        dp_rrftag_i    = SEL'(tag);
        wb1_en_i       = w1;
        wb1_rrftag_i   = SEL'(t1);
        wb2_en_i       = w2;
        wb2_rrftag_i   = SEL'(t2);
        stall_com_i    = st;
        reset          = rs;
        @(negedge clk);
    endtask

    // Compare DUT against the model for the current inputs, then advance the model.
    task automatic checkOutput();
        bit c1;
        bit c2;
        int e_ptr;
        int e_ptr2;
        int e_busy;
        int n;
        if (reset) begin
            c1 = 0; c2 = 0; e_ptr = 0; e_ptr2 = 1; e_busy = 0;
        end else begin
            c1     = !stall_com_i && q.size() > 0 && q[0].done;
            c2     = c1 && q.size() > 1 && q[1].done;
            e_ptr  = m_head;
            e_ptr2 = (m_head + 1) % N;
            e_busy = q.size();
        end
        checkEq("com_en1", int'(com_en1_o), int'(c1));
        checkEq("com_en2", int'(com_en2_o), int'(c2));
        checkEq("com_inst_num", int'(com_inst_num_o), int'(c1) + int'(c2));
        checkEq("comptr", int'(comptr_o), e_ptr);
        checkEq("comptr2", int'(comptr2_o), e_ptr2);
        checkEq("busy_num", int'(busy_num_o), e_busy);
        if (reset) begin
            q.delete();
            m_head = 0;
        end else begin
            foreach (q[i]) begin
                if (wb1_en_i && q[i].tag == int'(wb1_rrftag_i)) q[i].done = 1;
                if (wb2_en_i && q[i].tag == int'(wb2_rrftag_i)) q[i].done = 1;
            end
            n = int'(c1) + int'(c2);
            repeat (n) void'(q.pop_front());
            m_head = (m_head + n) % N;
            for (int k = 0; k < int'(dp_alloc_num_i); k++)
                q.push_back('{tag: (int'(dp_rrftag_i) + k) % N, done: 1'b0});
        end
    endtask

    task automatic drive(input int an, input int tag, input bit w1, input int t1,
                         input bit w2, input int t2, input bit st, input bit rs);
        applyStimulus(an, tag, w1, t1, w2, t2, st, rs);
        checkOutput();
    endtask

    task automatic idle();
        drive(0, tail(), 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dp_alloc_num_i = '0; dp_rrftag_i = '0; wb1_en_i = 0; wb2_en_i = 0;
        wb1_rrftag_i = '0; wb2_rrftag_i = '0; stall_com_i = 0; reset = 1;
        tick();

        // Reset overrides a same-cycle allocation and writeback.
        drive(2, 0, 1, 0, 0, 0, 0, 1);
        checkEq("rst_num", int'(com_inst_num_o), 0);
        checkEq("rst_ptr", int'(comptr_o), 0);
        checkEq("rst_ptr2", int'(comptr2_o), 1);
        checkEq("rst_busy", int'(busy_num_o), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();

        // Allocate 0,1; complete both; dual commit.
        drive(2, 0, 0, 0, 0, 0, 0, 0);
        checkEq("a_busy0", int'(busy_num_o), 0); tick();
        drive(0, 0, 1, 0, 1, 1, 0, 0);
        checkEq("a_busy2", int'(busy_num_o), 2);
        checkEq("a_nocommit", int'(com_inst_num_o), 0); tick();
        idle();
        checkEq("a_commit2", int'(com_inst_num_o), 2);
        checkEq("a_ptr0", int'(comptr_o), 0); tick();
        idle();
        checkEq("a_ptr2", int'(comptr_o), 2);
        checkEq("a_busy_after", int'(busy_num_o), 0); tick();

        // Walk the pointer to 5, then out-of-order completion of 5,6.
        drive(2, 2, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 4, 1, 2, 1, 3, 0, 0); tick();
        drive(0, 5, 1, 4, 0, 0, 0, 0);
        checkEq("b_commit23", int'(com_inst_num_o), 2); tick();
        idle();
        checkEq("b_commit4", int'(com_inst_num_o), 1); tick();
        drive(2, 5, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 7, 1, 6, 0, 0, 0, 0); tick();
        idle();
        checkEq("b_young_done", int'(com_inst_num_o), 0);
        checkEq("b_busy", int'(busy_num_o), 2); tick();
        drive(0, 7, 1, 5, 0, 0, 0, 0);
        checkEq("b_still0", int'(com_inst_num_o), 0); tick();
        idle();
        checkEq("b_commit56", int'(com_inst_num_o), 2);
        checkEq("b_ptr5", int'(comptr_o), 5); tick();

        // Stall holds two ready entries.
        drive(2, 7, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 9, 1, 7, 1, 8, 0, 0); tick();
        drive(0, 9, 0, 0, 0, 0, 1, 0);
        checkEq("c_stall_num", int'(com_inst_num_o), 0);
        checkEq("c_stall_ptr", int'(comptr_o), 7); tick();
        idle();
        checkEq("c_release", int'(com_inst_num_o), 2); tick();
        idle();
        checkEq("c_ptr9", int'(comptr_o), 9); tick();

        // Same-cycle alloc and writeback of tag 9: done must stay clear.
        drive(1, 9, 1, 9, 0, 0, 0, 0); tick();
        idle();
        checkEq("d_nocommit", int'(com_inst_num_o), 0); tick();
        drive(0, 10, 1, 9, 0, 0, 0, 0);
        checkEq("d_nocommit2", int'(com_inst_num_o), 0); tick();
        idle();
        checkEq("d_commit1", int'(com_inst_num_o), 1);
        checkEq("d_en2", int'(com_en2_o), 0); tick();

        // Walk the pointer to 63 one entry at a time (bounded).
        for (int i = 0; i < 400 && !(m_head == 63 && q.size() == 0); i++) begin
            if (q.size() == 0) drive(1, tail(), 0, 0, 0, 0, 0, 0);
            else if (!q[0].done) drive(0, tail(), 1, q[0].tag, 0, 0, 0, 0);
            else idle();
            tick();
        end
        idle();
        checkEq("e_ptr63", int'(comptr_o), 63); tick();
        drive(2, 63, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 63, 1, 0, 0, 0); tick();
        idle();
        checkEq("e_wrap_num", int'(com_inst_num_o), 2);
        checkEq("e_wrap_ptr2", int'(comptr2_o), 0); tick();
        idle();
        checkEq("e_ptr1", int'(comptr_o), 1);
        checkEq("e_busy0", int'(busy_num_o), 0); tick();

        // Four done entries held by stall, then abandoned by reset.
        drive(2, 1, 0, 0, 0, 0, 1, 0); tick();
        drive(2, 3, 1, 1, 1, 2, 1, 0); tick();
        drive(0, 5, 1, 3, 1, 4, 1, 0);
        checkEq("f_busy4", int'(busy_num_o), 4); tick();
        drive(0, 5, 0, 0, 0, 0, 0, 1);
        checkEq("f_rst_num", int'(com_inst_num_o), 0);
        checkEq("f_rst_busy", int'(busy_num_o), 0); tick();
        idle();
        checkEq("f_ptr0", int'(comptr_o), 0);
        checkEq("f_busy_after", int'(busy_num_o), 0);
        checkEq("f_num_after", int'(com_inst_num_o), 0); tick();

        // Randomized traffic; stall-heavy windows push occupancy toward full.
        for (int c = 0; c < 1500; c++) begin
            int an;
            int t1;
            int t2;
            bit w1;
            bit w2;
            bit st;
            bit rs;
            rs = ($urandom_range(0, 99) == 0);
            an = $urandom_range(0, 2);
            if (an > N - q.size()) an = N - q.size();
            w1 = 1'($urandom_range(0, 1));
            w2 = 1'($urandom_range(0, 1));
            if (q.size() > 0 && $urandom_range(0, 3) != 0) t1 = q[$urandom_range(0, q.size() - 1)].tag;
            else t1 = $urandom_range(0, N - 1);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) t2 = q[$urandom_range(0, q.size() - 1)].tag;
            else t2 = $urandom_range(0, N - 1);
            if (c % 400 < 150) st = ($urandom_range(0, 3) != 0);
            else st = ($urandom_range(0, 3) == 0);
            drive(an, tail(), w1, t1, w2, t2, st, rs);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rrf_commit_scheduler.md
RRF_COMMIT_SCHEDULER -- requirements
Module: rrf_commit_scheduler

Interface
REQ-001 SHALL take parameter RRF_NUM, default 64, number of rename-register-file entries.
REQ-002 SHALL take parameter RRF_SEL, default 6, log2(RRF_NUM) tag width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port dp_alloc_num_i  input  2  entries allocated this cycle (0..2; 3 illegal).
REQ-006 SHALL have port dp_rrftag_i  input  RRF_SEL  first allocated tag; second is (tag+1) mod RRF_NUM.
REQ-007 SHALL have ports wb1_en_i/wb2_en_i  input  1 each  writeback-complete strobes.
REQ-008 SHALL have ports wb1_rrftag_i/wb2_rrftag_i  input  RRF_SEL each  tags completing.
REQ-009 SHALL have port stall_com_i  input  1  inhibit all commit this cycle.
REQ-010 SHALL have port com_inst_num_o  output  2  entries committing this cycle (0..2), fed to the RRF allocator.
REQ-011 SHALL have ports com_en1_o/com_en2_o  output  1 each  architectural-write enables for slot 1/2.
REQ-012 SHALL have ports comptr_o/comptr2_o  output  RRF_SEL each  oldest tag and (oldest+1) mod RRF_NUM.
REQ-013 SHALL have port busy_num_o  output  RRF_SEL+1  count of valid (allocated, uncommitted) entries.

Function
REQ-014 SHALL hold per-entry valid[RRF_NUM] and done[RRF_NUM] bit vectors plus registered comptr and busy count.
REQ-015 SHALL, at the edge, set valid and clear done for each allocated tag (dp_alloc_num_i of them, from dp_rrftag_i, wrapping at RRF_NUM).
REQ-016 SHALL, at the edge, set done[tag] for each asserted wbN_en_i whose tag is valid; writeback to an invalid tag is ignored.
REQ-017 SHALL give allocation priority over writeback when both hit the same tag in one cycle (done ends cleared).
REQ-018 SHALL compute com_en1_o = ~stall_com_i & valid[comptr] & done[comptr] combinationally from registered state.
REQ-019 SHALL compute com_en2_o = com_en1_o & valid[comptr2] & done[comptr2]; slot 2 never commits without slot 1 (in-order).
REQ-020 SHALL drive com_inst_num_o = com_en1_o + com_en2_o in the same cycle.
REQ-021 SHALL, at the edge, clear valid and done of committed entries and advance comptr by com_inst_num_o modulo RRF_NUM.
REQ-022 SHALL update busy count as busy + dp_alloc_num_i - com_inst_num_o, range 0..RRF_NUM inclusive.
REQ-023 SHALL commit at the earliest in the cycle after the edge that set done (writeback-to-commit latency 1 cycle).
REQ-024 SHALL wrap comptr from RRF_NUM-1 to 0; comptr2_o wraps identically (comptr=RRF_NUM-1 -> comptr2=0).
REQ-025 SHALL treat allocation of an already-valid tag or busy count exceeding RRF_NUM as protocol errors (simulation assertion, no recovery).
REQ-026 SHALL permit allocate, two writebacks and two commits in one cycle with all effects applied at the same edge.
REQ-027 SHALL with busy=0 output com_inst_num_o=0 regardless of other inputs.

Reset
REQ-028 SHALL on reset at an edge clear all valid and done bits, comptr=0, busy=0, overriding any same-cycle alloc/writeback.
REQ-029 SHALL during and after reset drive com_en1_o=com_en2_o=0, com_inst_num_o=0, comptr_o=0, comptr2_o=1, busy_num_o=0.
REQ-030 SHALL abandon all in-flight entries when reset asserts mid-operation; no commit occurs in the reset cycle.

Structure
REQ-031 SHALL take RRF_NUM and RRF_SEL defaults from the shared Consts.v constants used by the RRF allocator.
REQ-032 SHALL be a single flat module; no sub-module (optional local ones-count function only).

Verification
REQ-033 Reset then alloc 2 at tag 0, wb tags 0,1 next cycle -> following cycle com_inst_num_o=2, comptr_o advances 0->2, busy 2->0.
REQ-034 Alloc tags 5,6; wb only tag 6 -> com_inst_num_o=0; then wb tag 5 -> next cycle com_inst_num_o=2.
REQ-035 Alloc tags 10,11, both done, stall_com_i=1 -> com_inst_num_o=0, comptr_o=10 held; deassert -> 2 commit.
REQ-036 comptr=63 with tags 63,0 done -> com_inst_num_o=2, comptr2_o=0, comptr_o becomes 1.
REQ-037 Same-cycle alloc tag 20 and wb tag 20 -> done[20]=0, no commit of 20 until a later writeback.
REQ-038 Reset asserted with 4 entries busy and done -> com_inst_num_o=0 in that cycle, busy_num_o=0, comptr_o=0 after.
